// File: rtl/adder_tree_acc_pipe.sv
// Pipelined N-lane reduction tree (one register stage per level) followed by a
// multi-beat accumulator framed by in_last, with valid/ready flow control.
module adder_tree_acc_pipe #(
  parameter int N        = 8,
  parameter int W        = 8,
  parameter int SIGNED   = 0,
  parameter int ACC_BITS = 4,
  localparam int L  = (N > 1) ? $clog2(N) : 1,
  localparam int OW = W + L + ACC_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic [ACC_BITS:0] out_count
);

  // Leaves are padded with zeros up to the next power of two.
  localparam int NP = 1 << L;

  // Bit offset of level s inside the flattened tree bus (level s has NP>>s nodes of W+s bits).
  function automatic int lvl_off(input int s);
    int o;
    o = 0;
    for (int j = 1; j < s; j++) begin
      o += (NP >> j) * (W + j);
    end
    return o;
  endfunction

  localparam int TOT = lvl_off(L + 1);

  logic                advance;
  logic                accept;
  logic [NP*W-1:0]     leaves;

  logic [TOT-1:0]      tree_sum;
  logic [TOT-1:0]      tree_q, tree_d;
  logic [L:1]          valid_q, valid_d;
  logic [L:1]          last_q, last_d;

  logic [OW-1:0]       acc_q, acc_d;
  logic [ACC_BITS:0]   acc_cnt_q, acc_cnt_d;
  logic                acc_open_q, acc_open_d;
  logic                out_valid_q, out_valid_d;
  logic [OW-1:0]       out_data_q, out_data_d;
  logic [ACC_BITS:0]   out_count_q, out_count_d;

  logic [W+L-1:0]      top;
  logic [OW-1:0]       top_ext;
  logic [OW-1:0]       acc_sum;
  logic [ACC_BITS:0]   cnt_base;
  logic [ACC_BITS:0]   cnt_inc;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign leaves   = (NP*W)'(in_data);

  genvar gi, gj;
  generate
    for (gi = 1; gi <= L; gi++) begin : g_lvl
      localparam int PW = W + gi - 1;
      localparam int LW = W + gi;
      localparam int NN = NP >> gi;

      logic [2*NN*PW-1:0] prev;

      if (gi == 1) begin : g_src
        assign prev = leaves;
      end else begin : g_src
        assign prev = tree_q[lvl_off(gi-1) +: 2*NN*PW];
      end

      for (gj = 0; gj < NN; gj++) begin : g_node
        logic [PW-1:0] a, b;
        logic [LW-1:0] ea, eb;

        assign a = prev[(2*gj)*PW +: PW];
        assign b = prev[(2*gj+1)*PW +: PW];

        if (SIGNED != 0) begin : g_ext
          assign ea = LW'($signed(a));
          assign eb = LW'($signed(b));
        end else begin : g_ext
          assign ea = LW'(a);
          assign eb = LW'(b);
        end

        // One extra bit per level makes each pairwise sum exact.
        assign tree_sum[lvl_off(gi) + gj*LW +: LW] = ea + eb;
      end
    end
  endgenerate

  assign top = tree_q[lvl_off(L) +: W+L];

  generate
    if (SIGNED != 0) begin : g_top_ext
      assign top_ext = OW'($signed(top));
    end else begin : g_top_ext
      assign top_ext = OW'(top);
    end
  endgenerate

  always_comb begin
    tree_d  = tree_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (advance) begin
      tree_d     = tree_sum;
      valid_d[1] = accept;
      last_d[1]  = in_last;
      for (int s = 2; s <= L; s++) begin
        valid_d[s] = valid_q[s-1];
        last_d[s]  = last_q[s-1];
      end
    end
  end

  // A closed frame restarts from zero; the beat counter sticks at all-ones.
  always_comb begin
    acc_sum  = (acc_open_q ? acc_q : '0) + top_ext;
    cnt_base = acc_open_q ? acc_cnt_q : '0;
    cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + (ACC_BITS+1)'(1);
  end

  always_comb begin
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    acc_open_d  = acc_open_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (advance) begin
      if (valid_q[L]) begin
        if (last_q[L]) begin
          out_data_d  = acc_sum;
          out_count_d = cnt_inc;
          out_valid_d = 1'b1;
          acc_open_d  = 1'b0;
        end else begin
          acc_d       = acc_sum;
          acc_cnt_d   = cnt_inc;
          acc_open_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q      <= '0;
      valid_q     <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      acc_open_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      tree_q      <= tree_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_open_q  <= acc_open_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_adder_tree_acc_pipe.sv
// Self-checking bench: three configurations (N=8 unsigned, N=5 signed, N=1 narrow acc)
// share handshake inputs; a frame-level model scoreboards every delivered result.
module tb_adder_tree_acc_pipe;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  always #5 clk = ~clk;

  logic [63:0] in_data_a;
  logic [39:0] in_data_b;
  logic [7:0]  in_data_c;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [14:0] out_data_a, out_data_b;
  logic [10:0] out_data_c;
  logic [4:0]  out_count_a, out_count_b;
  logic [2:0]  out_count_c;

  adder_tree_acc_pipe #(.N(8), .W(8), .SIGNED(0), .ACC_BITS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data_a),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_count(out_count_a));

  adder_tree_acc_pipe #(.N(5), .W(8), .SIGNED(1), .ACC_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_count(out_count_b));

  adder_tree_acc_pipe #(.N(1), .W(8), .SIGNED(0), .ACC_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data_c),
    .in_last(in_last), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .out_count(out_count_c));

  int lanes [3][8];

  always_comb begin
    in_data_a = '0;
    in_data_b = '0;
    in_data_c = '0;
    for (int k = 0; k < 8; k++) in_data_a[k*8 +: 8] = 8'(lanes[0][k]);
    for (int k = 0; k < 5; k++) in_data_b[k*8 +: 8] = 8'(lanes[1][k]);
    in_data_c = 8'(lanes[2][0]);
  end

  logic        ov [3];
  logic        ir [3];
  logic [63:0] od [3];
  logic [7:0]  oc [3];
  assign ov[0] = out_valid_a;  assign ov[1] = out_valid_b;  assign ov[2] = out_valid_c;
  assign ir[0] = in_ready_a;   assign ir[1] = in_ready_b;   assign ir[2] = in_ready_c;
  assign od[0] = 64'(out_data_a); assign od[1] = 64'(out_data_b); assign od[2] = 64'(out_data_c);
  assign oc[0] = 8'(out_count_a); assign oc[1] = 8'(out_count_b); assign oc[2] = 8'(out_count_c);

  // Per-configuration properties: lane count, signedness, output width, count saturation.
  function automatic int n_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 5 : 1;
  endfunction
  function automatic int ow_of(input int d);
    return (d == 2) ? 11 : 15;
  endfunction
  function automatic int sat_of(input int d);
    return (d == 2) ? 7 : 31;
  endfunction

  function automatic longint lane_sum(input int d);
    longint s;
    s = 0;
    for (int k = 0; k < n_of(d); k++) begin
      longint v;
      v = longint'(lanes[d][k] & 255);
      if (d == 1 && v >= 128) v = v - 256;
      s += v;
    end
    return s;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Frame-level scoreboard
  longint      exp_d [3][64];
  int          exp_c [3][64];
  int          wp [3], rp [3], fcnt [3];
  longint      fsum [3];
  logic        pv [3];
  logic [63:0] pd [3];
  logic        pr;

  initial begin
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0; rp[d] = 0; fsum[d] = 0; fcnt[d] = 0; pv[d] = 1'b0; pd[d] = '0;
    end
    pr = 1'b1;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          wp[d] = 0; rp[d] = 0; fsum[d] = 0; fcnt[d] = 0; pv[d] = 1'b0;
        end else begin
          if (pv[d] && !pr) begin
            n_checks++;
            if (!ov[d] || od[d] != pd[d]) begin
              n_fail++;
              $display("FAIL hold dut%0d: valid=%0b data=%0d, required valid=1 data=%0d",
                       d, ov[d], od[d], pd[d]);
            end
          end
          n_checks++;
          if (ir[d] !== (!ov[d] || out_ready)) begin
            n_fail++;
            $display("FAIL in_ready dut%0d: got %0b, required %0b", d, ir[d], !ov[d] || out_ready);
          end
          if (ov[d] && out_ready) begin
            n_checks++;
            if (rp[d] == wp[d]) begin
              n_fail++;
              $display("FAIL unexpected_output dut%0d: got data %0d, required no result", d, od[d]);
            end else begin
              if (od[d] != 64'(exp_d[d][rp[d] % 64]) || int'(oc[d]) != exp_c[d][rp[d] % 64]) begin
                n_fail++;
                $display("FAIL result dut%0d #%0d: got data %0d count %0d, required data %0d count %0d",
                         d, rp[d], od[d], oc[d], exp_d[d][rp[d] % 64], exp_c[d][rp[d] % 64]);
              end
              rp[d]++;
            end
          end
          if (in_valid && ir[d]) begin
            fsum[d] += lane_sum(d);
            fcnt[d]++;
            if (in_last) begin
              exp_d[d][wp[d] % 64] = fsum[d] & ((64'sd1 <<< ow_of(d)) - 1);
              exp_c[d][wp[d] % 64] = (fcnt[d] > sat_of(d)) ? sat_of(d) : fcnt[d];
              wp[d]++;
              fsum[d] = 0;
              fcnt[d] = 0;
            end
          end
          pv[d] = ov[d];
          pd[d] = od[d];
        end
      end
      pr = out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic last);
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Latency counted in edges from the final accept edge (edge 1).
  int          seen_lat [3], seen_n [3];
  logic [63:0] seen_d [3];
  int          seen_c [3];

  task automatic observe(input int edges);
    for (int d = 0; d < 3; d++) begin
      seen_lat[d] = 0; seen_n[d] = 0; seen_d[d] = '0; seen_c[d] = 0;
    end
    for (int e = 1; e <= edges; e++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          seen_n[d]++;
          if (seen_lat[d] == 0) begin
            seen_lat[d] = e; seen_d[d] = od[d]; seen_c[d] = int'(oc[d]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic set_seq_lanes();
    for (int k = 0; k < 8; k++) lanes[0][k] = k + 1;
    for (int k = 0; k < 5; k++) lanes[1][k] = k + 1;
    lanes[2][0] = 7;
  endtask

  int stall;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < 3; d++) for (int k = 0; k < 8; k++) lanes[d][k] = 0;
    tick(); tick();
    chk("reset out_valid_a", out_valid_a, 0);
    chk("reset out_data_a", out_data_a, 0);
    chk("reset out_count_a", out_count_a, 0);
    chk("reset out_valid_b", out_valid_b, 0);
    chk("reset out_valid_c", out_valid_c, 0);
    rst = 1'b0;
    tick(); tick();

    // Full-scale single beat, signed minimum, single-lane pass-through
    for (int k = 0; k < 8; k++) lanes[0][k] = 255;
    for (int k = 0; k < 4; k++) lanes[1][k] = -128;
    lanes[1][4] = 0;
    lanes[2][0] = 7;
    beat(1'b1);
    observe(8);
    chk("d1 a latency", seen_lat[0], 4);
    chk("d1 a data", seen_d[0], 2040);
    chk("d1 a count", seen_c[0], 1);
    chk("d1 b latency", seen_lat[1], 4);
    chk("d1 b data(-512)", seen_d[1], 32256);
    chk("d1 c latency", seen_lat[2], 2);
    chk("d1 c data", seen_d[2], 7);

    // Three-beat frame
    for (int k = 0; k < 8; k++) lanes[0][k] = k + 1;
    lanes[1][0] = 5; lanes[1][1] = -3; lanes[1][2] = 0; lanes[1][3] = -2; lanes[1][4] = 0;
    lanes[2][0] = 7;
    beat(1'b0); beat(1'b0); beat(1'b1);
    observe(8);
    chk("d2 a results", seen_n[0], 1);
    chk("d2 a latency", seen_lat[0], 4);
    chk("d2 a data", seen_d[0], 108);
    chk("d2 a count", seen_c[0], 3);
    chk("d2 b data", seen_d[1], 0);
    chk("d2 b count", seen_c[1], 3);
    chk("d2 c data", seen_d[2], 21);

    // Ten-beat frame: count saturation and modular wrap on the narrow config
    set_seq_lanes();
    lanes[2][0] = 255;
    for (int i = 0; i < 9; i++) beat(1'b0);
    beat(1'b1);
    observe(8);
    chk("d3 a data", seen_d[0], 360);
    chk("d3 a count", seen_c[0], 10);
    chk("d3 b data", seen_d[1], 150);
    chk("d3 b latency", seen_lat[1], 4);
    chk("d3 c data(wrap)", seen_d[2], 502);
    chk("d3 c count(sat)", seen_c[2], 7);

    // Continuous per-beat stream with a 5-cycle consumer stall
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) lanes[0][k] = i + 1;
      for (int k = 0; k < 5; k++) lanes[1][k] = i + 1;
      lanes[2][0] = i + 1;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      out_ready = !(i >= 8 && i < 13);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    for (int d = 0; d < 3; d++) chk($sformatf("stall drain dut%0d", d), wp[d] - rp[d], 0);

    // Reset in the middle of an open frame
    set_seq_lanes();
    beat(1'b0); beat(1'b0);
    rst = 1'b1;
    tick();
    chk("midreset out_valid_a", out_valid_a, 0);
    chk("midreset out_data_a", out_data_a, 0);
    chk("midreset out_count_a", out_count_a, 0);
    rst = 1'b0;
    tick();
    beat(1'b1);
    observe(8);
    chk("d6 a data", seen_d[0], 36);
    chk("d6 a count", seen_c[0], 1);
    chk("d6 a results", seen_n[0], 1);

    // Randomized traffic with backpressure bursts
    stall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 8; k++) begin
          int r;
          r = int'($urandom % 8);
          lanes[d][k] = (r == 0) ? 0 : (r == 1) ? 255 : (r == 2) ? 128 : int'($urandom % 256);
        end
      end
      in_valid = ($urandom % 10) < 7;
      in_last  = ($urandom % 4) == 0;
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else if ($urandom % 20 == 0) begin
        stall     = int'($urandom_range(1, 6));
        out_ready = 1'b0;
      end else begin
        out_ready = ($urandom % 4) != 0;
      end
      tick();
    end
    in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (10) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("final drain dut%0d", d), wp[d] - rp[d], 0);
      chk($sformatf("results seen dut%0d", d), (rp[d] > 100) ? 1 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
